// File: rtl/morse_char_encoder.sv
// Morse transmitter: accepts a 6-bit character code (1=A..26=Z) and keys it out on morse_out.
// Optional MORSE_TX_WORD_GAP_EN: code 27 keys a 7-unit word space instead of raising err.
module morse_char_encoder #(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_code,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       morse_out,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = $clog2(7 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_TX_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WGAP_LD = CNT_W'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, CGAP, WGAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, MARK, SPACE, CGAP} state_e;
`endif

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       len_q, len_nxt;
  logic [3:0]       pat_q, pat_nxt;
  logic             err_nxt;
  logic [6:0]       rom_entry;

  // {len[2:0], pattern[3:0]}; pattern is left-aligned, bit 3 is the first symbol, 1 = dash.
  // len 0 marks an unmapped code.
  function automatic logic [6:0] morse_rom(input logic [5:0] code);
    case (code)
      6'd1:    morse_rom = {3'd2, 4'b0100}; // A .-
      6'd2:    morse_rom = {3'd4, 4'b1000}; // B -...
      6'd3:    morse_rom = {3'd4, 4'b1010}; // C -.-.
      6'd4:    morse_rom = {3'd3, 4'b1000}; // D -..
      6'd5:    morse_rom = {3'd1, 4'b0000}; // E .
      6'd6:    morse_rom = {3'd4, 4'b0010}; // F ..-.
      6'd7:    morse_rom = {3'd3, 4'b1100}; // G --.
      6'd8:    morse_rom = {3'd4, 4'b0000}; // H ....
      6'd9:    morse_rom = {3'd2, 4'b0000}; // I ..
      6'd10:   morse_rom = {3'd4, 4'b0111}; // J .---
      6'd11:   morse_rom = {3'd3, 4'b1010}; // K -.-
      6'd12:   morse_rom = {3'd4, 4'b0100}; // L .-..
      6'd13:   morse_rom = {3'd2, 4'b1100}; // M --
      6'd14:   morse_rom = {3'd2, 4'b1000}; // N -.
      6'd15:   morse_rom = {3'd3, 4'b1110}; // O ---
      6'd16:   morse_rom = {3'd4, 4'b0110}; // P .--.
      6'd17:   morse_rom = {3'd4, 4'b1101}; // Q --.-
      6'd18:   morse_rom = {3'd3, 4'b0100}; // R .-.
      6'd19:   morse_rom = {3'd3, 4'b0000}; // S ...
      6'd20:   morse_rom = {3'd1, 4'b1000}; // T -
      6'd21:   morse_rom = {3'd3, 4'b0010}; // U ..-
      6'd22:   morse_rom = {3'd4, 4'b0001}; // V ...-
      6'd23:   morse_rom = {3'd3, 4'b0110}; // W .--
      6'd24:   morse_rom = {3'd4, 4'b1001}; // X -..-
      6'd25:   morse_rom = {3'd4, 4'b1011}; // Y -.--
      6'd26:   morse_rom = {3'd4, 4'b1100}; // Z --..
      default: morse_rom = 7'd0;
    endcase
  endfunction

  assign rom_entry  = morse_rom(char_code);
  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    len_nxt   = len_q;
    pat_nxt   = pat_q;
    err_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (rom_entry[6:4] != 3'd0) begin
            state_nxt = MARK;
            len_nxt   = rom_entry[6:4];
            pat_nxt   = rom_entry[3:0];
            cnt_nxt   = rom_entry[3] ? DASH_LD : DOT_LD;
`ifdef MORSE_TX_WORD_GAP_EN
          end else if (char_code == 6'd27) begin
            state_nxt = WGAP;
            cnt_nxt   = WGAP_LD;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else if (len_q > 3'd1) begin
          state_nxt = SPACE;
          cnt_nxt   = DOT_LD;
          len_nxt   = len_q - 3'd1;
          pat_nxt   = {pat_q[2:0], 1'b0};
        end else begin
          state_nxt = CGAP;
          cnt_nxt   = DASH_LD;
        end
      end
      SPACE: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end else begin
          state_nxt = MARK;
          cnt_nxt   = pat_q[3] ? DASH_LD : DOT_LD;
        end
      end
      CGAP: begin
        if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
        else             state_nxt = IDLE;
      end
`ifdef MORSE_TX_WORD_GAP_EN
      WGAP: begin
        if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
        else             state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // morse_out is registered from the next state so it changes exactly on state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      pat_q     <= '0;
      err       <= 1'b0;
      morse_out <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      len_q     <= len_nxt;
      pat_q     <= pat_nxt;
      err       <= err_nxt;
      morse_out <= (state_nxt == MARK);
    end
  end

endmodule
